// File: rtl/bitserial_logic16_if.sv
// Parallel request/response bundle for the bit-serial logic unit.
// The master drives the operands and start; the slave returns status and the result.
interface bitserial_logic16_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (output start, op, a, b, input busy, done, out);
  modport slave  (input start, op, a, b, output busy, done, out);
endinterface

// File: rtl/bitserial_logic16.sv
// Bit-serial NOT/AND/OR/XOR unit: operands are shifted out LSB first through a
// single 1-bit function, and the result is reassembled into a parallel word.
module bitserial_logic16 #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  bitserial_logic16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, acc, res;
  logic [1:0]       opr;
  logic [3:0]       cnt;
  logic             r, last, accept;

  function automatic logic bit_op(input logic [1:0] o, input logic x, input logic y);
    case (o)
      2'b00:   bit_op = ~x;
      2'b01:   bit_op = x & y;
      2'b10:   bit_op = x | y;
      default: bit_op = x ^ y;
    endcase
  endfunction

  assign r      = bit_op(opr, sa[0], sb[0]);
  assign last   = (cnt == 4'(WIDTH-1));
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Result bits enter at the MSB so bit i lands at position i after WIDTH shifts.
  always_ff @(posedge clock) begin
    if (reset) begin
      sa  <= '0;
      sb  <= '0;
      acc <= '0;
      opr <= 2'b00;
      cnt <= 4'd0;
      res <= '0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      opr <= bus.op;
      acc <= '0;
      cnt <= 4'd0;
    end else if (state == RUN) begin
      acc <= {r, acc[WIDTH-1:1]};
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cnt <= cnt + 4'd1;
      if (last) res <= {r, acc[WIDTH-1:1]};
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.out  = res;
endmodule

// File: doc/bitserial_logic16.md
# bitserial_logic16

Bit-serial 16-bit logic unit: it accepts two parallel 16-bit operands and an opcode, then evaluates NOT/AND/OR/XOR one bit per clock, LSB first, through a single 1-bit datapath. It reassembles the result into a parallel 16-bit word. It is the serial counterpart of the parallel 16-bit gate arrays and serves as the area-minimal logic path next to the ALU. Parallel operands go in, serial evaluation runs internally, and a parallel result comes back with a done pulse.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..16; bit counter is 4 bits wide.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all state at the next rising edge of clock.
- start  input  1  request; sampled only when state is IDLE or DONE.
- op  input  2  operation, latched with start: 00 = NOT a (b ignored), 01 = a AND b, 10 = a OR b, 11 = a XOR b.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- busy  output  1  high while state is RUN.
- done  output  1  single-cycle pulse, high while state is DONE.
- out  output  WIDTH  last completed result; held stable between completions.

## Operation
- Internal registers:
  - state: IDLE, RUN or DONE.
  - sa, sb: WIDTH-bit operand shift registers.
  - acc: WIDTH-bit result shift register.
  - opr: 2-bit latched opcode.
  - cnt: 4-bit bit index.
  - out: result register.
- IDLE:
  - start=1 → latch sa=a, sb=b, opr=op, cnt=0, acc=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, one bit per edge:
  - Compute bit r = f(opr, sa[0], sb[0]).
  - acc ← {r, acc[WIDTH-1:1]} (result shifts in at the MSB, so bit i lands at position i after WIDTH shifts).
  - sa ← sa>>1, sb ← sb>>1, cnt ← cnt+1.
  - On the edge where cnt == WIDTH-1: also load out ← {r, acc[WIDTH-1:1]} and go to DONE.
- DONE, lasts one cycle:
  - start=1 → latch new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - start=0 → go to IDLE.
- start while in RUN is ignored. Latched operands, op and the count are unaffected.
- Changes on a, b or op after the latching edge have no effect on the running operation.
- out changes only at the completing edge of RUN and at reset. It never shows a partial result.
- Reset in any state, including mid-RUN:
  - state=IDLE, busy=0, done=0, out=0, cnt=0, acc=0, sa=0, sb=0, opr=00.
  - The in-flight operation is discarded.
  - reset has priority over start in the same cycle.

## Timing
- Start accepted at edge E (state IDLE or DONE) → RUN during the cycles following edges E..E+WIDTH-1.
- busy=1 after edge E, for WIDTH cycles.
- out updates at edge E+WIDTH.
- done=1 for exactly the one cycle after edge E+WIDTH.
- Latency from the start-sampling edge to done: WIDTH+1 edges (17 for WIDTH=16).
- Throughput: one operation per WIDTH+1 cycles when start is held high continuously.
- busy and done are never high simultaneously.
- Both are registered outputs (decoded from state), with no combinational path from inputs.
- Reset values: busy=0, done=0, out=0.

## Test plan
- AND: after reset, a=F0F0, b=3C3C, op=01, start for 1 cycle. Required:
  - busy high for 16 cycles.
  - done high for 1 cycle, 17 edges after start.
  - out=3030 from that cycle on.
  - out=0000 throughout RUN.
- All ops on the same operands, a=F0F0, b=3C3C:
  - op=10 → out=FCFC.
  - op=11 → out=CCCC.
  - op=00 with a=00FF, b=1234 → out=FF00 (b ignored).
- Back-to-back: start held high continuously with AND then OR on F0F0/3C3C. Required:
  - The second op is accepted in the DONE cycle.
  - done pulses are exactly 17 cycles apart.
  - out goes 3030 → FCFC.
  - busy is low only during the DONE cycles.
- Ignored inputs: during RUN, pulse start and flip a=FFFF, b=FFFF, op=10 at cycle 5. Required: the original AND result 3030 with a single done pulse.
- Reset mid-RUN: assert reset for 1 cycle at RUN cycle 8 of the OR on F0F0/3C3C, after a prior completed result 3030. Required:
  - out=0000, busy=0, done=0 after the reset edge.
  - No done pulse follows.
  - A subsequent XOR completes with out=CCCC.
- Reset priority: reset=1 and start=1 in the same cycle while in IDLE. Required: the unit stays in IDLE with busy=0 and no done pulse afterwards.
